joybus_host: RTL and testbench

Host-side (PIF-side) Joybus transceiver. Drives a command frame of up to 63 bytes onto the single-wire controller line. It then receives a fixed-length response from the controller-port device and streams the received bytes out one at a time. It sits between the PIF command/RAM logic and a controller port, and forms the initiator end of the controller-emulation link.

---
 rtl/joybus_if.sv | 26 ++
 rtl/joybus_host.sv | 184 ++++++++++++++++++
 tb/tb_joybus_host.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/joybus_if.sv
// PIF-side command/response handshake of the Joybus host transceiver.
// master = PIF logic and command RAM, slave = joybus_host.
interface joybus_if;
    logic       start;
    logic [5:0] tx_len;
    logic [5:0] rx_len;
    logic [5:0] tx_addr;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [5:0] rx_addr;
    logic [5:0] rx_count;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        output start, tx_len, rx_len, tx_data,
        input  tx_addr, rx_valid, rx_data, rx_addr, rx_count, busy, done, timeout
    );

    modport slave (
        input  start, tx_len, rx_len, tx_data,
        output tx_addr, rx_valid, rx_data, rx_addr, rx_count, busy, done, timeout
    );
endinterface

// File: rtl/joybus_host.sv
// Joybus host transceiver: sends a command frame on the open-drain line, then
// decodes the device response by low-pulse width and streams the bytes out.
module joybus_host #(
    parameter int CLKS_PER_US = 50,
    parameter int TIMEOUT_US  = 100
) (
    input  logic    clock,
    input  logic    reset_l,
    joybus_if.slave bus,
    inout  wire     joy
);
    localparam int TO_CYC = TIMEOUT_US * CLKS_PER_US;
    localparam int CW     = $clog2(TO_CYC + 4 * CLKS_PER_US + 2);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t C1  = cnt_t'(CLKS_PER_US);
    localparam cnt_t C2  = cnt_t'(2 * CLKS_PER_US);
    localparam cnt_t C3  = cnt_t'(3 * CLKS_PER_US);
    localparam cnt_t TO  = cnt_t'(TO_CYC);
    localparam cnt_t ONE = cnt_t'(1);

    typedef enum logic [3:0] {
        IDLE, LOAD, TX_LOW, TX_HIGH, STOP_LOW,
        RX_WAIT, RX_LOW, RX_STOP_WAIT, RX_STOP_LOW, DONE
    } state_t;

    state_t     state;
    cnt_t       cnt;
    logic       drive;
    logic       joy_m, joy_s, joy_d;
    logic [5:0] tx_len_q, rx_len_q;
    logic [7:0] tx_sh, rx_sh;
    logic [2:0] bit_cnt, rx_bits;
    cnt_t       low_len, high_len;
    logic       last_byte, fall, rise, rx_bit;

    // Open drain: the driver register is async-reset, so reset releases the line at once.
    assign joy = drive ? 1'b0 : 1'bz;

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            joy_m <= 1'b1;
            joy_s <= 1'b1;
            joy_d <= 1'b1;
        end else begin
            joy_m <= joy;
            joy_s <= joy_m;
            joy_d <= joy_s;
        end
    end

    assign fall      = joy_d & ~joy_s;
    assign rise      = ~joy_d & joy_s;
    assign rx_bit    = (cnt < C2);
    assign last_byte = (bus.tx_addr == tx_len_q - 6'd1);

    // Bit 0 of a non-final byte gives up 2 high cycles to the next LOAD.
    always_comb begin
        low_len  = tx_sh[7] ? C1 : C3;
        high_len = tx_sh[7] ? C3 : C1;
        if (bit_cnt == 3'd0 && !last_byte)
            high_len = high_len - cnt_t'(2);
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state        <= IDLE;
            cnt          <= '0;
            drive        <= 1'b0;
            tx_len_q     <= '0;
            rx_len_q     <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            bit_cnt      <= '0;
            rx_bits      <= '0;
            bus.tx_addr  <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_addr  <= '0;
            bus.rx_count <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.timeout  <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    tx_len_q     <= bus.tx_len;
                    rx_len_q     <= bus.rx_len;
                    bus.rx_count <= '0;
                    bus.timeout  <= 1'b0;
                    bus.tx_addr  <= '0;
                    cnt          <= '0;
                    rx_bits      <= '0;
                    if (bus.tx_len == 6'd0) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: if (cnt == ONE) begin
                    tx_sh   <= bus.tx_data;
                    bit_cnt <= 3'd7;
                    drive   <= 1'b1;
                    cnt     <= '0;
                    state   <= TX_LOW;
                end else cnt <= cnt + ONE;
                TX_LOW: if (cnt == low_len - ONE) begin
                    drive <= 1'b0;
                    cnt   <= '0;
                    state <= TX_HIGH;
                end else cnt <= cnt + ONE;
                TX_HIGH: if (cnt == high_len - ONE) begin
                    cnt <= '0;
                    if (bit_cnt != 3'd0) begin
                        bit_cnt <= bit_cnt - 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        drive   <= 1'b1;
                        state   <= TX_LOW;
                    end else if (!last_byte) begin
                        bus.tx_addr <= bus.tx_addr + 6'd1;
                        state       <= LOAD;
                    end else begin
                        drive <= 1'b1;
                        state <= STOP_LOW;
                    end
                end else cnt <= cnt + ONE;
                STOP_LOW: if (cnt == C1 - ONE) begin
                    drive <= 1'b0;
                    cnt   <= '0;
                    if (rx_len_q == 6'd0) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end else state <= RX_WAIT;
                end else cnt <= cnt + ONE;
                RX_WAIT, RX_STOP_WAIT: if (fall) begin
                    cnt   <= ONE;
                    state <= (state == RX_WAIT) ? RX_LOW : RX_STOP_LOW;
                end else if (rise) begin
                    cnt <= '0;
                end else if (cnt == TO - ONE) begin
                    bus.timeout <= 1'b1;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= DONE;
                end else cnt <= cnt + ONE;
                RX_LOW: if (rise) begin
                    rx_sh   <= {rx_sh[6:0], rx_bit};
                    rx_bits <= rx_bits + 3'd1;
                    cnt     <= '0;
                    state   <= RX_WAIT;
                    if (rx_bits == 3'd7) begin
                        bus.rx_valid <= 1'b1;
                        bus.rx_data  <= {rx_sh[6:0], rx_bit};
                        bus.rx_addr  <= bus.rx_count;
                        bus.rx_count <= bus.rx_count + 6'd1;
                        if (bus.rx_count + 6'd1 == rx_len_q)
                            state <= RX_STOP_WAIT;
                    end
                end else if (cnt >= TO) begin
                    bus.timeout <= 1'b1;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= DONE;
                end else cnt <= cnt + ONE;
                RX_STOP_LOW: if (rise) begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= DONE;
                end else if (cnt >= TO) begin
                    bus.timeout <= 1'b1;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= DONE;
                end else cnt <= cnt + ONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_joybus_host.sv
// Directed bench for joybus_host: line monitor, command RAM model, bench-side
// device emitting responses, and an rx scoreboard queue.
module tb_joybus_host;
    logic clock   = 1'b0;
    logic reset_l = 1'b0;
    logic dev_low = 1'b0;
    wire  joy;

    always #5 clock = ~clock;

    joybus_if bus ();
    assign joy = dev_low ? 1'b0 : 1'bz;
    pullup (joy);

    joybus_host #(.CLKS_PER_US(50), .TIMEOUT_US(100)) dut (
        .clock(clock), .reset_l(reset_l), .bus(bus), .joy(joy)
    );

    // Command RAM: one registered read stage, data settled by the 2nd edge.
    logic [7:0] mem [64];
    always @(posedge clock) bus.tx_data <= mem[bus.tx_addr];

    int          cyc = 0;
    logic        joy_p = 1'b1;
    logic [5:0]  addr_p = '0;
    int          fall_q[$], rise_q[$], low_q[$], done_q[$], start_q[$], addr_q[$];
    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];

    always @(negedge clock) begin
        cyc++;
        if (joy_p && !joy) fall_q.push_back(cyc);
        if (!joy_p && joy) begin
            rise_q.push_back(cyc);
            if (fall_q.size() > 0) low_q.push_back(cyc - fall_q[$]);
        end
        joy_p = joy;
        if (bus.done)     done_q.push_back(cyc);
        if (bus.start)    start_q.push_back(cyc);
        if (bus.rx_valid) got_q.push_back({bus.rx_addr, bus.rx_data});
        if (bus.tx_addr != addr_p) addr_q.push_back(int'(bus.tx_addr));
        addr_p = bus.tx_addr;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(int tl, int rl);
        bus.tx_len = 6'(tl);
        bus.rx_len = 6'(rl);
        bus.start  = 1'b1;
        tick(1);
        bus.start  = 1'b0;
    endtask

    task automatic wait_rises(string tag, int n, int budget);
        int k = 0;
        while (rise_q.size() < n && k < budget) begin
            @(posedge clock); #1; k++;
        end
        chk(tag, 32'(rise_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(string tag, int n, int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge clock); #1; k++;
        end
        chk(tag, 32'(done_q.size() >= n), 32'd1);
    endtask

    task automatic dev_bit(int lowlen);
        dev_low = 1'b1;
        tick(lowlen);
        dev_low = 1'b0;
        tick(200 - lowlen);
    endtask

    task automatic dev_byte(int addr, logic [7:0] b, int w1, int w0);
        exp_q.push_back({6'(addr), b});
        for (int i = 7; i >= 0; i--) dev_bit(b[i] ? w1 : w0);
    endtask

    task automatic dev_stop();
        dev_low = 1'b1;
        tick(100);
        dev_low = 1'b0;
        tick(20);
    endtask

    // Pops every expected byte and compares it with the pulses seen since gb.
    task automatic check_rx(string tag, int gb);
        logic [13:0] e, g;
        chk({tag, "_pulses"}, 32'(got_q.size() - gb), 32'(exp_q.size()));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (gb + i < got_q.size()) ? got_q[gb + i] : 14'bx;
            chk({tag, "_byte"}, 32'(g), 32'(e));
        end
    endtask

    initial begin
        repeat (98000) @(posedge clock);
        $display("FAIL watchdog: observed no finish, expected finish before 98000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, db, gb, lb, fb, sb, ab, bad;
        logic [7:0] byte_v;
        logic       ok;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        bus.start  = 1'b0;
        bus.tx_len = '0;
        bus.rx_len = '0;
        tick(5);
        chk("rst_joy",      32'(joy),          32'd1);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
        chk("rst_tx_addr",  32'(bus.tx_addr),  32'd0);
        chk("rst_rx_data",  32'(bus.rx_data),  32'd0);
        chk("rst_rx_addr",  32'(bus.rx_addr),  32'd0);
        reset_l = 1'b1;
        tick(3);

        // Status: 0x00 out, 05 00 01 back.
        mem[0] = 8'h00;
        rb = rise_q.size(); db = done_q.size(); gb = got_q.size();
        lb = low_q.size();  fb = fall_q.size(); sb = start_q.size();
        pulse_start(1, 3);
        chk("status_busy", 32'(bus.busy), 32'd1);
        wait_rises("status_tx_wait", rb + 9, 3000);
        chk("status_first_fall", 32'(fall_q[fb] - start_q[sb]), 32'd3);
        for (int i = 0; i < 8; i++) chk("status_tx_low", 32'(low_q[lb + i]), 32'd150);
        chk("status_stop_low", 32'(low_q[lb + 8]), 32'd50);
        tick(10);
        dev_byte(0, 8'h05, 50, 150);
        dev_byte(1, 8'h00, 50, 150);
        dev_byte(2, 8'h01, 50, 150);
        dev_stop();
        wait_done("status_done_wait", db + 1, 500);
        tick(2);
        chk("status_done_once", 32'(done_q.size() - db), 32'd1);
        chk("status_timeout",   32'(bus.timeout),  32'd0);
        chk("status_rx_count",  32'(bus.rx_count), 32'd3);
        chk("status_busy_end",  32'(bus.busy),     32'd0);
        check_rx("status_rx", gb);

        // No device: release + 2 sync + 1 edge-detect + 5000 timeout.
        mem[0] = 8'h01;
        rb = rise_q.size(); db = done_q.size(); gb = got_q.size();
        pulse_start(1, 4);
        wait_rises("nodev_tx_wait", rb + 9, 3000);
        wait_done("nodev_done_wait", db + 1, 6000);
        chk("nodev_done_delay", 32'(done_q[db] - rise_q[rb + 8]), 32'd5003);
        chk("nodev_timeout",    32'(bus.timeout),  32'd1);
        chk("nodev_rx_count",   32'(bus.rx_count), 32'd0);
        check_rx("nodev_rx", gb);

        // Truncated: 2 of 4 bytes, then silence.
        rb = rise_q.size(); db = done_q.size(); gb = got_q.size();
        pulse_start(1, 4);
        chk("trunc_timeout_cleared", 32'(bus.timeout), 32'd0);
        wait_rises("trunc_tx_wait", rb + 9, 3000);
        tick(10);
        dev_byte(0, 8'h12, 50, 150);
        dev_byte(1, 8'hB4, 50, 150);
        wait_done("trunc_done_wait", db + 1, 6000);
        chk("trunc_timeout",  32'(bus.timeout),  32'd1);
        chk("trunc_rx_count", 32'(bus.rx_count), 32'd2);
        check_rx("trunc_rx", gb);

        // Threshold: 99 low is a 1, 100 low is a 0.
        rb = rise_q.size(); db = done_q.size(); gb = got_q.size();
        pulse_start(1, 1);
        wait_rises("thr_tx_wait", rb + 9, 3000);
        tick(10);
        dev_byte(0, 8'hAA, 99, 100);
        dev_stop();
        wait_done("thr_done_wait", db + 1, 500);
        chk("thr_timeout",  32'(bus.timeout),  32'd0);
        chk("thr_rx_count", 32'(bus.rx_count), 32'd1);
        check_rx("thr_rx", gb);

        // Write frame: 35 bytes out, 1 back.
        for (int i = 0; i < 35; i++) mem[i] = 8'((i * 37 + 11) ^ (i << 3));
        rb = rise_q.size(); db = done_q.size(); gb = got_q.size();
        lb = low_q.size();  fb = fall_q.size(); ab = addr_q.size();
        pulse_start(35, 1);
        wait_rises("wr_tx_wait", rb + 281, 60000);
        chk("wr_addr_steps", 32'(addr_q.size() - ab), 32'd34);
        for (int k = 0; k < 34 && ab + k < addr_q.size(); k++)
            chk("wr_addr", 32'(addr_q[ab + k]), 32'(k + 1));
        for (int i = 0; i < 35; i++) begin
            ok = 1'b1;
            byte_v = '0;
            for (int j = 0; j < 8; j++) begin
                byte_v = {byte_v[6:0], low_q[lb + 8 * i + j] == 50};
                if (low_q[lb + 8 * i + j] != 50 && low_q[lb + 8 * i + j] != 150) ok = 1'b0;
            end
            chk("wr_byte", {23'd0, ok, byte_v}, {23'd0, 1'b1, mem[i]});
        end
        bad = 0;
        for (int k = 0; k < 280; k++)
            if (fall_q[fb + k + 1] - fall_q[fb + k] != 200) bad++;
        chk("wr_cell_len",  32'(bad), 32'd0);
        chk("wr_stop_low",  32'(low_q[lb + 280]), 32'd50);
        chk("wr_total_time", 32'(rise_q[rb + 280] - fall_q[fb]), 32'd56050);
        tick(10);
        dev_byte(0, 8'hC3, 50, 150);
        dev_stop();
        wait_done("wr_done_wait", db + 1, 500);
        chk("wr_timeout",  32'(bus.timeout),  32'd0);
        chk("wr_rx_count", 32'(bus.rx_count), 32'd1);
        check_rx("wr_rx", gb);

        // start while busy must not restart; rx_len=0 ends at stop release.
        mem[0] = 8'hFF;
        mem[1] = 8'h00;
        rb = rise_q.size(); db = done_q.size(); fb = fall_q.size(); sb = start_q.size();
        pulse_start(1, 0);
        tick(100);
        pulse_start(2, 0);
        wait_done("busy_done_wait", db + 1, 3000);
        tick(5);
        chk("busy_falls",      32'(fall_q.size() - fb), 32'd9);
        chk("busy_done_once",  32'(done_q.size() - db), 32'd1);
        chk("busy_done_time",  32'(done_q[db] - rise_q[rb + 8]), 32'd0);
        chk("busy_frame_time", 32'(done_q[db] - start_q[sb]), 32'd1653);

        // tx_len=0: done the cycle after start, line untouched.
        fb = fall_q.size(); db = done_q.size(); sb = start_q.size();
        pulse_start(0, 2);
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        tick(5);
        chk("zero_done_time", 32'(done_q.size() > db ? done_q[db] - start_q[sb] : -1), 32'd1);
        chk("zero_no_drive",  32'(fall_q.size() - fb), 32'd0);

        // Reset in the middle of a low phase.
        mem[0] = 8'h00;
        db = done_q.size();
        pulse_start(1, 0);
        tick(20);
        chk("mid_line_low", 32'(joy), 32'd0);
        reset_l = 1'b0;
        #1;
        chk("mid_rst_joy",  32'(joy),      32'd1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        tick(3);
        reset_l = 1'b1;
        tick(10);
        chk("mid_rst_no_done", 32'(done_q.size() - db), 32'd0);
        chk("mid_rst_joy_after", 32'(joy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
